// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin master arbiter with serial slave-ID decode
// and split-read reconnection for the shared serial address/data bus.
module bus_arbiter #(
    parameter int NM      = 2,
    parameter int NS      = 3,
    parameter int SIDW    = 2,
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [NM-1:0] mreq,
    input  logic [NM-1:0] mvalid,
    input  logic [NM-1:0] maddr,
    input  logic [NS-1:0] ssplit,
    input  logic [NS-1:0] sready,
    output logic [NM-1:0] mgrant,
    output logic [NS-1:0] ssel,
    output logic [NS-1:0] bus_avail,
    output logic          merr,
    output logic          busy
);
    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(N + 3);
    localparam int BW = $clog2(SIDW) + 1;

    typedef enum logic [2:0] {IDLE, SEL, CONN, RESUME, ERR} state_t;

    state_t          r_state, w_state;
    logic [MW-1:0]   r_gm, w_gm;
    logic [MW-1:0]   r_rr, w_rr;
    logic [SW-1:0]   r_sel, w_sel;
    logic [SIDW-1:0] r_id, w_id;
    logic [BW-1:0]   r_bcnt, w_bcnt;
    logic [TW-1:0]   r_tcnt, w_tcnt;
    logic [RW-1:0]   r_rcnt, w_rcnt;
    logic [NS-1:0]   r_pend, w_pend;
    logic [MW-1:0]   r_split_m [NS];
    logic [MW-1:0]   w_split_m [NS];
    logic [NM-1:0]   r_mgrant, w_mgrant;
    logic [NS-1:0]   r_ssel, w_ssel;
    logic [NS-1:0]   r_bavail, w_bavail;
    logic            r_merr, w_merr;

    logic [NM-1:0]   w_owned;
    logic            w_cpl_hit;
    logic [SW-1:0]   w_cpl_s;
    logic            w_rr_hit;
    logic [MW-1:0]   w_rr_m;
    logic [SIDW-1:0] w_id_sh;
    logic            w_id_ok;

    function automatic logic [MW-1:0] rr_idx(logic [MW-1:0] base, int off);
        return MW'((int'(base) + off) % NM);
    endfunction

    // Descending loops: the last hit written is the highest priority one
    always_comb begin
        w_owned = '0;
        for (int s = 0; s < NS; s++)
            if (r_pend[s]) w_owned[r_split_m[s]] = 1'b1;
        w_cpl_hit = 1'b0;
        w_cpl_s   = '0;
        for (int s = NS - 1; s >= 0; s--)
            if (r_pend[s] && sready[s]) begin
                w_cpl_hit = 1'b1;
                w_cpl_s   = SW'(s);
            end
        w_rr_hit = 1'b0;
        w_rr_m   = '0;
        for (int i = NM; i >= 1; i--)
            if (mreq[rr_idx(r_rr, i)] && !w_owned[rr_idx(r_rr, i)]) begin
                w_rr_hit = 1'b1;
                w_rr_m   = rr_idx(r_rr, i);
            end
        w_id_sh = SIDW'({r_id, maddr[r_gm]});
        w_id_ok = (int'(w_id_sh) < NS) && !r_pend[SW'(w_id_sh)];
    end

    always_comb begin
        w_state   = r_state;
        w_gm      = r_gm;
        w_rr      = r_rr;
        w_sel     = r_sel;
        w_id      = r_id;
        w_bcnt    = r_bcnt;
        w_tcnt    = r_tcnt;
        w_rcnt    = r_rcnt;
        w_pend    = r_pend;
        w_split_m = r_split_m;
        w_mgrant  = r_mgrant;
        w_ssel    = r_ssel;
        w_bavail  = r_bavail;
        w_merr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cpl_hit) begin
                    w_state  = RESUME;
                    w_gm     = r_split_m[w_cpl_s];
                    w_sel    = w_cpl_s;
                    w_rcnt   = '0;
                    w_mgrant = NM'(1) << r_split_m[w_cpl_s];
                    w_ssel   = NS'(1) << w_cpl_s;
                    w_bavail = NS'(1) << w_cpl_s;
                end else if (w_rr_hit) begin
                    w_state  = SEL;
                    w_gm     = w_rr_m;
                    w_rr     = w_rr_m;
                    w_id     = '0;
                    w_bcnt   = '0;
                    w_mgrant = NM'(1) << w_rr_m;
                end
            end
            SEL: begin
                if (!mreq[r_gm]) begin
                    w_state  = IDLE;
                    w_mgrant = '0;
                end else if (mvalid[r_gm]) begin
                    w_id   = w_id_sh;
                    w_bcnt = r_bcnt + 1'b1;
                    if (r_bcnt == BW'(SIDW - 1)) begin
                        if (w_id_ok) begin
                            w_state = CONN;
                            w_sel   = SW'(w_id_sh);
                            w_ssel  = NS'(1) << SW'(w_id_sh);
                            w_tcnt  = '0;
                        end else begin
                            w_state  = ERR;
                            w_merr   = 1'b1;
                            w_mgrant = '0;
                        end
                    end
                end
            end
            CONN: begin
                if (r_tcnt != '1) w_tcnt = r_tcnt + 1'b1;
                if (!mreq[r_gm]) begin
                    w_state  = IDLE;
                    w_mgrant = '0;
                    w_ssel   = '0;
                end else if (ssplit[r_sel]) begin
                    w_pend[r_sel]    = 1'b1;
                    w_split_m[r_sel] = r_gm;
                    w_state          = IDLE;
                    w_mgrant         = '0;
                    w_ssel           = '0;
                end else if (w_tcnt == TW'(TIMEOUT)) begin
                    w_merr   = 1'b1;
                    w_state  = IDLE;
                    w_mgrant = '0;
                    w_ssel   = '0;
                end
            end
            RESUME: begin
                // Load cycle, N data bits, one trailing cycle
                if (r_rcnt == RW'(N + 1)) begin
                    w_pend[r_sel] = 1'b0;
                    w_state       = IDLE;
                    w_mgrant      = '0;
                    w_ssel        = '0;
                    w_bavail      = '0;
                end else begin
                    w_rcnt = r_rcnt + 1'b1;
                end
            end
            ERR: begin
                w_mgrant = '0;
                if (!mreq[r_gm]) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_gm     <= '0;
            r_rr     <= MW'(NM - 1);
            r_sel    <= '0;
            r_id     <= '0;
            r_bcnt   <= '0;
            r_tcnt   <= '0;
            r_rcnt   <= '0;
            r_pend   <= '0;
            for (int s = 0; s < NS; s++) r_split_m[s] <= '0;
            r_mgrant <= '0;
            r_ssel   <= '0;
            r_bavail <= '0;
            r_merr   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gm      <= w_gm;
            r_rr      <= w_rr;
            r_sel     <= w_sel;
            r_id      <= w_id;
            r_bcnt    <= w_bcnt;
            r_tcnt    <= w_tcnt;
            r_rcnt    <= w_rcnt;
            r_pend    <= w_pend;
            r_split_m <= w_split_m;
            r_mgrant  <= w_mgrant;
            r_ssel    <= w_ssel;
            r_bavail  <= w_bavail;
            r_merr    <= w_merr;
        end
    end

    assign mgrant    = r_mgrant;
    assign ssel      = r_ssel;
    assign bus_avail = r_bavail;
    assign merr      = r_merr;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table vectors, directed split/timeout/reset sequences
// and a randomized run against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int NM = 2;
    localparam int NS = 3;
    localparam int SIDW = 2;
    localparam int N = 8;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NM-1:0] mreq = '0, mvalid = '0, maddr = '0;
    logic [NS-1:0] ssplit = '0, sready = '0;
    logic [NM-1:0] mgrant;
    logic [NS-1:0] ssel, bus_avail;
    logic merr, busy;

    bus_arbiter #(.NM(NM), .NS(NS), .SIDW(SIDW), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .mreq(mreq), .mvalid(mvalid), .maddr(maddr),
        .ssplit(ssplit), .sready(sready), .mgrant(mgrant), .ssel(ssel),
        .bus_avail(bus_avail), .merr(merr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        mreq = '0; mvalid = '0; maddr = '0; ssplit = '0; sready = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Reference model: bus phase plus countdowns, split table as arrays
    localparam int P_FREE = 0, P_ADDR = 1, P_CONN = 2, P_REPLAY = 3, P_FAULT = 4;
    int ph, own, last, idv, nb, tgt, age, left;
    bit m_pend [NS];
    int m_who [NS];
    bit e_err;

    task automatic model_reset();
        ph = P_FREE; own = 0; last = NM - 1; idv = 0; nb = 0;
        tgt = 0; age = 0; left = 0; e_err = 1'b0;
        for (int s = 0; s < NS; s++) begin
            m_pend[s] = 1'b0;
            m_who[s] = 0;
        end
    endtask

    function automatic bit owns(int m);
        for (int s = 0; s < NS; s++)
            if (m_pend[s] && m_who[s] == m) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int found;
        e_err = 1'b0;
        case (ph)
            P_FREE: begin
                found = -1;
                for (int s = 0; s < NS; s++)
                    if (found < 0 && m_pend[s] && sready[s]) found = s;
                if (found >= 0) begin
                    ph = P_REPLAY; tgt = found; own = m_who[found]; left = N + 2;
                end else begin
                    for (int k = 1; k <= NM; k++) begin
                        int m;
                        m = (last + k) % NM;
                        if (ph == P_FREE && mreq[m] && !owns(m)) begin
                            ph = P_ADDR; own = m; last = m; idv = 0; nb = 0;
                        end
                    end
                end
            end
            P_ADDR: begin
                if (!mreq[own]) ph = P_FREE;
                else if (mvalid[own]) begin
                    idv = idv * 2 + int'(maddr[own]);
                    nb++;
                    if (nb == SIDW) begin
                        if (idv < NS && !m_pend[idv]) begin
                            ph = P_CONN; tgt = idv; age = 0;
                        end else begin
                            ph = P_FAULT; e_err = 1'b1;
                        end
                    end
                end
            end
            P_CONN: begin
                age++;
                if (!mreq[own]) ph = P_FREE;
                else if (ssplit[tgt]) begin
                    m_pend[tgt] = 1'b1; m_who[tgt] = own; ph = P_FREE;
                end else if (age >= TIMEOUT) begin
                    e_err = 1'b1; ph = P_FREE;
                end
            end
            P_REPLAY: begin
                left--;
                if (left == 0) begin
                    m_pend[tgt] = 1'b0; ph = P_FREE;
                end
            end
            P_FAULT: if (!mreq[own]) ph = P_FREE;
            default: ph = P_FREE;
        endcase
    endtask

    function automatic logic [31:0] model_out();
        logic [NM-1:0] g;
        logic [NS-1:0] s, a;
        g = '0; s = '0; a = '0;
        if (ph == P_ADDR || ph == P_CONN || ph == P_REPLAY) g[own] = 1'b1;
        if (ph == P_CONN || ph == P_REPLAY) s[tgt] = 1'b1;
        if (ph == P_REPLAY) a[tgt] = 1'b1;
        return 32'({g, s, a, e_err, ph != P_FREE});
    endfunction

    typedef struct packed {
        logic [1:0] req, vld, adr, g;
        logic [2:0] s;
        logic e, b;
    } vec_t;
    vec_t tbl [14];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int j;
        int cnt;
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b1};
        tbl[1]  = '{2'b01, 2'b01, 2'b00, 2'b01, 3'b000, 1'b0, 1'b1};
        tbl[2]  = '{2'b01, 2'b01, 2'b01, 2'b01, 3'b010, 1'b0, 1'b1};
        tbl[3]  = '{2'b01, 2'b00, 2'b00, 2'b01, 3'b010, 1'b0, 1'b1};
        tbl[4]  = '{2'b01, 2'b00, 2'b00, 2'b01, 3'b010, 1'b0, 1'b1};
        tbl[5]  = '{2'b01, 2'b00, 2'b00, 2'b01, 3'b010, 1'b0, 1'b1};
        tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{2'b10, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b1};
        tbl[8]  = '{2'b10, 2'b10, 2'b10, 2'b10, 3'b000, 1'b0, 1'b1};
        tbl[9]  = '{2'b10, 2'b10, 2'b10, 2'b00, 3'b000, 1'b1, 1'b1};
        tbl[10] = '{2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1};
        tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b1};
        tbl[13] = '{2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};

        @(negedge clk);
        chk("reset_outs", 32'({mgrant, ssel, bus_avail, merr, busy}), 32'(0));
        do_reset();

        // Single write, bad ID, pointer rotation
        for (int i = 0; i < 14; i++) begin
            mreq = tbl[i].req; mvalid = tbl[i].vld; maddr = tbl[i].adr;
            cyc();
            chk($sformatf("tbl%0d_grant", i), 32'(mgrant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_ssel", i), 32'(ssel), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_merr", i), 32'(merr), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
        end

        // Contention: grants alternate
        do_reset();
        mreq = 2'b11;
        cyc();
        for (int t = 0; t < 4; t++) begin
            logic [1:0] want;
            want = (t % 2 == 1) ? 2'b10 : 2'b01;
            chk($sformatf("cont%0d_grant", t), 32'(mgrant), 32'(want));
            mvalid = want; maddr = 2'b00;
            cyc(); cyc();
            chk($sformatf("cont%0d_ssel", t), 32'(ssel), 32'(3'b001));
            mvalid = 2'b00;
            repeat (10) cyc();
            mreq = 2'b11 & ~want;
            cyc();
            chk($sformatf("cont%0d_drop", t), 32'(mgrant), 32'(0));
            mreq = 2'b11;
            cyc();
        end

        // Split read
        do_reset();
        mreq = 2'b01;
        cyc();
        chk("split_g0", 32'(mgrant), 32'(2'b01));
        mvalid = 2'b01; maddr = 2'b01;
        cyc();
        maddr = 2'b00;
        cyc();
        chk("split_ssel2", 32'(ssel), 32'(3'b100));
        mvalid = 2'b00;
        repeat (3) cyc();
        ssplit = 3'b100;
        cyc();
        ssplit = 3'b000;
        chk("split_rel", 32'({mgrant, ssel}), 32'(0));
        mreq = 2'b11;
        cyc();
        chk("split_m1_grant", 32'(mgrant), 32'(2'b10));
        mvalid = 2'b10; maddr = 2'b00;
        cyc(); cyc();
        chk("split_m1_ssel", 32'(ssel), 32'(3'b001));
        mvalid = 2'b00;
        repeat (3) cyc();
        mreq = 2'b01;
        cyc();
        chk("split_m1_drop", 32'(mgrant), 32'(0));
        cyc();
        chk("split_m0_blocked", 32'({mgrant, busy}), 32'(0));
        sready = 3'b100;
        cyc();
        chk("resume_outs", 32'({mgrant, ssel, bus_avail}), 32'({2'b01, 3'b100, 3'b100}));
        sready = 3'b000;
        cnt = (bus_avail == 3'b100) ? 1 : 0;
        for (int i = 1; i < 12; i++) begin
            cyc();
            if (bus_avail == 3'b100) cnt++;
            if (i == 10) chk("resume_end_grant", 32'(mgrant), 32'(0));
            if (i == 11) chk("resume_regrant", 32'(mgrant), 32'(2'b01));
        end
        chk("resume_len", 32'(cnt), 32'(N + 2));

        // Timeout
        do_reset();
        mreq = 2'b11;
        cyc();
        mvalid = 2'b01; maddr = 2'b00;
        cyc(); cyc();
        chk("to_ssel", 32'(ssel), 32'(3'b001));
        mvalid = 2'b00;
        j = 0;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            if (j == 0 && merr) j = i;
            if (j != 0) break;
        end
        chk("to_cycle", 32'(j), 32'(TIMEOUT));
        chk("to_drop", 32'({mgrant, ssel}), 32'(0));
        cyc();
        chk("to_next", 32'({mgrant, merr}), 32'({2'b10, 1'b0}));

        // Reset mid-RESUME
        do_reset();
        mreq = 2'b11;
        cyc();
        mvalid = 2'b01; maddr = 2'b01;
        cyc();
        maddr = 2'b00;
        cyc();
        mvalid = 2'b00;
        ssplit = 3'b100;
        cyc();
        ssplit = 3'b000;
        mreq = 2'b00;
        repeat (2) cyc();
        sready = 3'b100;
        cyc();
        chk("rr_resume", 32'(bus_avail), 32'(3'b100));
        repeat (3) cyc();
        #2;
        rstn = 1'b0;
        #1;
        chk("rr_async", 32'({mgrant, ssel, bus_avail, merr, busy}), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        mreq = 2'b11;
        cyc();
        chk("rr_after", 32'({mgrant, bus_avail}), 32'({2'b01, 3'b000}));

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < NM; m++)
                if ($urandom_range(7) == 0) mreq[m] = ~mreq[m];
            mvalid = NM'($urandom);
            maddr = NM'($urandom);
            for (int s = 0; s < NS; s++) begin
                ssplit[s] = ($urandom_range(11) == 0);
                sready[s] = ($urandom_range(3) == 0);
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk($sformatf("rand%0d", c),
                32'({mgrant, ssel, bus_avail, merr, busy}), model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
